// File: rtl/p_down_timer_pkg.sv
// -----------------------------------------------------------------------------
// p_down_timer_pkg
// Shared definitions for the down-counting timer: FSM state encodings and
// operating mode constants.
// -----------------------------------------------------------------------------
package p_down_timer_pkg;

    // FSM states. The encoding is fixed so that software and other blocks in
    // the counter subsystem can decode the state consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operating modes latched on start.
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage : p_down_timer_pkg

// File: rtl/p_down_timer.sv
// -----------------------------------------------------------------------------
// p_down_timer
// Programmable down-counting timer driven by the tick (carry out) of an
// upstream prescaler counter. A start pulse latches a period P and a mode;
// the timer then counts P ticks down to zero and emits a one-cycle borrow
// pulse. In one-shot mode it parks in DONE; in auto-reload mode it reloads
// the latched period and keeps running.
//
// Ports:
//   i_clk      system clock, rising edge active
//   i_reset_n  asynchronous active-low reset
//   i_start    pulse: latch i_period / i_mode and (re)start counting
//   i_stop     pulse: abort and return to IDLE (highest priority)
//   i_cin      tick from the upstream counter, one decrement per high cycle
//   i_period   ticks per period (P), sampled on an accepted start
//   i_mode     0 = one-shot, 1 = auto-reload, sampled on an accepted start
//   o_cnt      current count value
//   o_borrow   registered one-cycle pulse after the terminal tick
//   o_busy     high while in RUN
//   o_done     high while in DONE
// -----------------------------------------------------------------------------
module p_down_timer
    import p_down_timer_pkg::*;
#(
    parameter int CNT_WIDTH      = 4,
    parameter int DEFAULT_PERIOD = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_cin,
    input  logic [CNT_WIDTH-1:0] i_period,
    input  logic                 i_mode,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_borrow,
    output logic                 o_busy,
    output logic                 o_done
);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 mode_q;
    logic                 borrow;

    // Value loaded into the count register for a period of p ticks. Counting
    // p-1 down to 0 and borrowing on the tick seen at 0 gives exactly p ticks
    // per period. A period of 0 behaves like 1 so the counter never has to
    // represent p-1 = -1.
    function automatic logic [CNT_WIDTH-1:0] load_value(input logic [CNT_WIDTH-1:0] p);
        return (p == '0) ? '0 : p - CNT_WIDTH'(1);
    endfunction

    // Single FSM + datapath process. Priority on every edge: stop, then
    // start, then tick. Borrow defaults low so it can never stretch beyond
    // one cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            borrow   <= 1'b0;
            period_q <= CNT_WIDTH'(DEFAULT_PERIOD);
            mode_q   <= MODE_ONESHOT;
        end else begin
            borrow <= 1'b0;
            if (i_stop) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (i_start) begin
                // A restart always wins over a coincident terminal tick, so
                // no borrow is produced on this edge.
                period_q <= i_period;
                mode_q   <= i_mode;
                cnt      <= load_value(i_period);
                state    <= ST_RUN;
            end else if (state == ST_RUN && i_cin) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_WIDTH'(1);
                end else begin
                    borrow <= 1'b1;
                    if (mode_q == MODE_RELOAD) begin
                        cnt <= load_value(period_q);
                    end else begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end
                end
            end
        end
    end

    assign o_cnt    = cnt;
    assign o_borrow = borrow;
    assign o_busy   = (state == ST_RUN);
    assign o_done   = (state == ST_DONE);

endmodule : p_down_timer

// File: tb/tb_p_down_timer.sv
module tb_p_down_timer;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_cin = 1'b0;
    logic [3:0] i_period = 4'd0;
    logic       i_mode = 1'b0;
    logic [3:0] o_cnt;
    logic       o_borrow;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    p_down_timer #(.CNT_WIDTH(4), .DEFAULT_PERIOD(12)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_cin     (i_cin),
        .i_period  (i_period),
        .i_mode    (i_mode),
        .o_cnt     (o_cnt),
        .o_borrow  (o_borrow),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: tracks how many ticks remain until the borrow
    // (1..P while running) rather than a count register.
    int m_phase;      // 0 idle, 1 running, 2 finished
    int m_left;
    int m_per;
    bit m_reload;
    bit m_borrow;

    function automatic void model_reset();
        m_phase  = 0;
        m_left   = 1;
        m_per    = 12;
        m_reload = 1'b0;
        m_borrow = 1'b0;
    endfunction

    function automatic void model_step(bit stop, bit start, bit cin, int per, bit md);
        m_borrow = 1'b0;
        if (stop) begin
            m_phase = 0;
        end else if (start) begin
            m_per    = (per == 0) ? 1 : per;
            m_reload = md;
            m_left   = m_per;
            m_phase  = 1;
        end else if (m_phase == 1 && cin) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_borrow = 1'b1;
                if (m_reload) m_left = m_per;
                else          m_phase = 2;
            end
        end
    endfunction

    function automatic logic [6:0] exp_vec();
        int c;
        c = (m_phase == 1) ? (m_left - 1) : 0;
        return {4'(c), m_borrow, (m_phase == 1), (m_phase == 2)};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {o_cnt, o_borrow, o_busy, o_done};
    endfunction

    // Apply inputs for one clock edge, advance the model, and return #1 after
    // the edge so outputs can be sampled away from it.
    task automatic drive(input bit stop, input bit start, input bit cin,
                         input logic [3:0] per, input bit md);
        i_stop   = stop;
        i_start  = start;
        i_cin    = cin;
        i_period = per;
        i_mode   = md;
        @(posedge i_clk);
        model_step(stop, start, cin, int'(per), md);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_start = i[0];
            i_cin   = ~i[0];
            i_period = 4'd5;
            @(posedge i_clk);
            #1;
            checks++;
            if (dut_vec() !== 7'b0) begin
                errors++;
                $display("FAIL reset_held cycle %0d: got %b want %b", i, dut_vec(), 7'b0);
            end
        end
        i_start = 1'b0;
        i_cin   = 1'b0;
        #2 i_reset_n = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
        checks++;
        if (dut_vec() !== exp_vec() || dut_vec() !== 7'b0) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", dut_vec(), 7'b0);
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] want [5];
        want = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        drive(0, 1, 1, 4'd5, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) drive(0, 0, 1, 4'd0, 0);
            checks++;
            if (o_cnt !== want[i] || o_borrow !== 1'b0 || o_busy !== 1'b1 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL oneshot_cnt edge %0d: got %b want cnt %0d vec %b", i, dut_vec(), want[i], exp_vec());
            end
        end
        drive(0, 0, 1, 4'd0, 0);
        checks++;
        if (dut_vec() !== 7'b0000_1_0_1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL oneshot_borrow: got %b want %b", dut_vec(), 7'b0000_1_0_1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 4'd9, 1);
            checks++;
            if (dut_vec() !== 7'b0000_0_0_1 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL oneshot_done_hold %0d: got %b want %b", i, dut_vec(), 7'b0000_0_0_1);
            end
        end
    endtask

    task automatic test_reload();
        int nb;
        bit prev;
        nb = 0;
        prev = 1'b0;
        drive(0, 1, 0, 4'd3, 1);
        for (int i = 0; i < 24; i++) begin
            drive(0, 0, (i % 2 == 0), 4'd0, 0);
            if (o_borrow) nb++;
            checks++;
            if (dut_vec() !== exp_vec() || o_busy !== 1'b1 || (prev && o_borrow)) begin
                errors++;
                $display("FAIL reload cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            prev = o_borrow;
        end
        checks++;
        if (nb !== 4) begin
            errors++;
            $display("FAIL reload_borrow_count: got %0d want 4", nb);
        end
    endtask

    task automatic test_stop();
        drive(0, 1, 0, 4'd12, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 4'd0, 0);
        checks++;
        if (o_cnt !== 4'd7 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stop_precount: got cnt %0d want 7", o_cnt);
        end
        drive(1, 0, 1, 4'd0, 0);
        checks++;
        if (dut_vec() !== 7'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stop_abort: got %b want %b", dut_vec(), 7'b0);
        end
        drive(0, 1, 0, 4'd6, 1);
        drive(1, 1, 1, 4'd9, 1);
        checks++;
        if (dut_vec() !== 7'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stop_over_start: got %b want %b", dut_vec(), 7'b0);
        end
    endtask

    task automatic test_start_override();
        drive(0, 1, 0, 4'd2, 0);
        drive(0, 0, 1, 4'd0, 0);
        checks++;
        if (o_cnt !== 4'd0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL override_setup: got %b want cnt 0 busy 1", dut_vec());
        end
        drive(0, 1, 1, 4'd7, 0);
        checks++;
        if (dut_vec() !== 7'b0110_0_1_0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL override_restart: got %b want %b", dut_vec(), 7'b0110_0_1_0);
        end
        drive(1, 0, 0, 4'd0, 0);
    endtask

    task automatic test_short_periods();
        for (int p = 0; p < 2; p++) begin
            drive(0, 1, 1, 4'(p), 1);
            checks++;
            if (dut_vec() !== 7'b0000_0_1_0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL short_p%0d_load: got %b want %b", p, dut_vec(), 7'b0000_0_1_0);
            end
            for (int i = 0; i < 5; i++) begin
                drive(0, 0, 1, 4'd0, 0);
                checks++;
                if (dut_vec() !== 7'b0000_1_1_0 || dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL short_p%0d cycle %0d: got %b want %b", p, i, dut_vec(), 7'b0000_1_1_0);
                end
            end
        end
        drive(1, 0, 0, 4'd0, 0);
    endtask

    task automatic test_reset_mid_run();
        drive(0, 1, 0, 4'd1, 0);
        drive(0, 0, 1, 4'd0, 0);
        checks++;
        if (o_borrow !== 1'b1 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: got %b want borrow 1 done 1", dut_vec());
        end
        drive(0, 1, 1, 4'd9, 1);
        drive(0, 0, 1, 4'd0, 0);
        #2 i_reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 7'b0) begin
            errors++;
            $display("FAIL midreset_async: got %b want %b", dut_vec(), 7'b0);
        end
        i_cin = 1'b0;
        #1 i_reset_n = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_random();
        bit st, sp, c, md;
        logic [3:0] p;
        for (int i = 0; i < 600; i++) begin
            sp = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 9) == 0);
            c  = $urandom_range(0, 1) != 0;
            md = $urandom_range(0, 1) != 0;
            p  = 4'($urandom_range(0, 15));
            drive(sp, st, c, p, md);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_oneshot();
        test_reload();
        test_stop();
        test_start_override();
        test_short_periods();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_p_down_timer
